// File: rtl/board_loader.sv
// Board loader: sweeps a fill pattern into the board double buffer on request, one word per cycle.
// Optional LFSR random fill is compiled in with the LOADER_LFSR_EN macro.
module board_loader #(
    parameter int          ADDR_W = 12,
    parameter int          DATA_W = 16,
    parameter int          WORDS  = 4096,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              load_req_in,
    input  logic [1:0]        mode_in,
    output logic [ADDR_W-1:0] addr_w_out,
    output logic [DATA_W-1:0] data_w_out,
    output logic              wr_en_out,
    output logic              busy_out,
    output logic              done_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    state_t              state_r, state_nxt_s;
    logic                pending_r, pending_nxt_s;
    logic [1:0]          mode_r, mode_nxt_s;
    logic [1:0]          sweep_mode_r, sweep_mode_nxt_s;
    logic [1:0]          eff_mode_s;
    logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
    logic [DATA_W-1:0]   data_r, data_nxt_s;
    logic                wr_en_r, wr_en_nxt_s;
    logic                done_r, done_nxt_s;
    logic                busy_r;
    logic [DATA_W-1:0]   rnd_word_s;

    function automatic logic [DATA_W-1:0] fill_word(input logic [1:0] mode, input logic odd,
                                                     input logic [DATA_W-1:0] rnd);
        logic [DATA_W-1:0] w;
        w = {DATA_W{1'b0}};
        case (mode)
            2'b00:   w = {DATA_W{1'b0}};
            2'b01:   w = rnd;
            2'b10:   for (int i = 0; i < DATA_W; i++) w[i] = ((i % 2) == 0) ^ odd;
            2'b11:   w = {DATA_W{1'b1}};
            default: w = {DATA_W{1'b0}};
        endcase
        return w;
    endfunction

`ifdef LOADER_LFSR_EN
    logic [15:0] lfsr_r;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [DATA_W-1:0] lfsr_replicate(input logic [15:0] s);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W; i++) w[i] = s[i % 16];
        return w;
    endfunction

    assign rnd_word_s = lfsr_replicate(lfsr_r);

    // LFSR state: advances once for every word written
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lfsr_r <= SEED;
        end else if (wr_en_nxt_s) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`else
    logic unused_seed_s;
    assign unused_seed_s = ^SEED;
    assign rnd_word_s    = {DATA_W{1'b0}};
`endif

    // A request arriving together with start is served by that start
    assign eff_mode_s = load_req_in ? mode_in : mode_r;

    // Next-state and next-output logic
    always_comb begin
        state_nxt_s      = state_r;
        pending_nxt_s    = pending_r | load_req_in;
        mode_nxt_s       = eff_mode_s;
        sweep_mode_nxt_s = sweep_mode_r;
        wr_en_nxt_s      = 1'b0;
        addr_nxt_s       = {ADDR_W{1'b0}};
        data_nxt_s       = {DATA_W{1'b0}};
        done_nxt_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_in && (pending_r || load_req_in)) begin
                    pending_nxt_s    = 1'b0;
                    sweep_mode_nxt_s = eff_mode_s;
                    state_nxt_s      = SWEEP;
                    wr_en_nxt_s      = 1'b1;
                    data_nxt_s       = fill_word(eff_mode_s, 1'b0, rnd_word_s);
                end else if (start_in) begin
                    state_nxt_s = DONE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SWEEP: begin
                if (addr_r == LAST_ADDR) begin
                    state_nxt_s = DONE;
                    done_nxt_s  = 1'b1;
                end else begin
                    wr_en_nxt_s = 1'b1;
                    addr_nxt_s  = addr_r + ADDR_W'(1);
                    data_nxt_s  = fill_word(sweep_mode_r, addr_nxt_s[0], rnd_word_s);
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r      <= IDLE;
            pending_r    <= 1'b0;
            mode_r       <= 2'b00;
            sweep_mode_r <= 2'b00;
            addr_r       <= {ADDR_W{1'b0}};
            data_r       <= {DATA_W{1'b0}};
            wr_en_r      <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pending_r    <= pending_nxt_s;
            mode_r       <= mode_nxt_s;
            sweep_mode_r <= sweep_mode_nxt_s;
            addr_r       <= addr_nxt_s;
            data_r       <= data_nxt_s;
            wr_en_r      <= wr_en_nxt_s;
            done_r       <= done_nxt_s;
            busy_r       <= (state_nxt_s != IDLE);
        end
    end

    assign addr_w_out = addr_r;
    assign data_w_out = data_r;
    assign wr_en_out  = wr_en_r;
    assign done_out   = done_r;
    assign busy_out   = busy_r;

endmodule

// File: tb/tb_board_loader.sv
// Randomized scoreboard bench for board_loader (WORDS=8); follows LOADER_LFSR_EN if defined.
module tb_board_loader;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        load_req = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [11:0] addr_w;
    logic [15:0] data_w;
    logic        wr_en, busy, done;

    board_loader #(.ADDR_W(12), .DATA_W(16), .WORDS(W), .SEED(16'hACE1)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .load_req_in(load_req),
        .mode_in(mode), .addr_w_out(addr_w), .data_w_out(data_w), .wr_en_out(wr_en),
        .busy_out(busy), .done_out(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_done;
        int          addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        m_pend;
    logic [1:0]  m_mode;
    logic [15:0] m_lfsr;
    int          b_start, b_end;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_pend  = 1'b0;
        m_mode  = 2'b00;
        m_lfsr  = 16'hACE1;
        b_start = 1;
        b_end   = 0;
        exp_q.delete();
    endfunction

    // One word of a sweep, derived from the fill rules
    function automatic logic [15:0] model_word(input logic [1:0] md, input int k);
        logic [15:0] w;
        case (md)
            2'b11:   w = 16'hFFFF;
            2'b10:   w = (k % 2 == 0) ? 16'h5555 : 16'hAAAA;
`ifdef LOADER_LFSR_EN
            2'b01:   w = m_lfsr;
`endif
            default: w = 16'h0000;
        endcase
`ifdef LOADER_LFSR_EN
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
        return w;
    endfunction

    function automatic void model_cycle(input logic ld, input logic [1:0] md, input logic st, input int s);
        if (ld) begin
            m_pend = 1'b1;
            m_mode = md;
        end
        if (st && s > b_end) begin
            if (m_pend) begin
                m_pend = 1'b0;
                for (int k = 0; k < W; k++)
                    exp_q.push_back('{1'b0, k, model_word(m_mode, k), s + 1 + k});
                exp_q.push_back('{1'b1, 0, 16'h0000, s + 1 + W});
                b_start = s + 1;
                b_end   = s + 1 + W;
            end else begin
                exp_q.push_back('{1'b1, 0, 16'h0000, s + 1});
                b_start = s + 1;
                b_end   = s + 1;
            end
        end
    endfunction

    task automatic drive_cycle(input logic ld, input logic [1:0] md, input logic st);
        load_req = ld;
        mode     = md;
        start    = st;
        model_cycle(ld, md, st, cyc);
        @(posedge clk);
        #1;
        load_req = 1'b0;
        start    = 1'b0;
        mode     = 2'b00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 2'b00, 1'b0);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_wr"}, int'(wr_en), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_addr"}, int'(addr_w), 0);
        check({name, "_data"}, int'(data_w), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or signals done
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", int'(busy), int'(cyc >= b_start && cyc <= b_end));
            if (wr_en || done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", int'({wr_en, done}), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ev_kind", int'({wr_en, done}), e.is_done ? 1 : 2);
                    check("ev_cycle", cyc, e.cyc);
                    if (!e.is_done) begin
                        check("ev_addr", int'(addr_w), e.addr);
                        check("ev_data", int'(data_w), int'(e.data));
                    end
                end
            end
            if (!wr_en) begin
                check("idle_addr", int'(addr_w), 0);
                check("idle_data", int'(data_w), 0);
            end
            if (exp_q.size() != 0 && cyc > exp_q[0].cyc)
                check("missed_event", cyc, exp_q[0].cyc);
        end
    end

    initial begin
        int s;
        logic [15:0] first_w, second_w;
`ifdef LOADER_LFSR_EN
        first_w  = 16'hACE1;
        second_w = 16'h5670;
`else
        first_w  = 16'h0000;
        second_w = 16'h0000;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // start with nothing pending: pass-through done
        drive_cycle(1'b0, 2'b00, 1'b1);
        idle(3);

        // checkerboard sweep
        drive_cycle(1'b1, 2'b10, 1'b0);
        idle(1);
        drive_cycle(1'b0, 2'b00, 1'b1);
        idle(W + 3);

        // fresh reset, then random mode requested together with start
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        drive_cycle(1'b1, 2'b01, 1'b1);
        @(negedge clk);
        check("rnd_first", int'(data_w), int'(first_w));
        @(negedge clk);
        check("rnd_second", int'(data_w), int'(second_w));
        @(posedge clk);
        #1;
        idle(W + 2);

        // request and stray starts during a sweep
        drive_cycle(1'b1, 2'b00, 1'b1);
        idle(1);
        drive_cycle(1'b0, 2'b00, 1'b1);
        drive_cycle(1'b1, 2'b11, 1'b0);
        idle(1);
        drive_cycle(1'b0, 2'b00, 1'b1);
        idle(W);
        drive_cycle(1'b0, 2'b00, 1'b1);
        idle(W + 3);

        // random traffic
        for (int i = 0; i < 400; i++)
            drive_cycle(($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                        ($urandom_range(0, 5) == 0));
        idle(W + 3);

        // reset in cycle 4 of a sweep
        drive_cycle(1'b1, 2'b11, 1'b1);
        idle(3);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(W + 2);
        s = total;
        drive_cycle(1'b0, 2'b00, 1'b1);
        idle(3);
        check("post_reset_passthrough_seen", int'(total > s + 3), 1);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
